// File: rtl/bcd_sume_n.sv
// bcd_sume_n: keypad-driven BCD calculator with debounced key events and a digit-serial adder.
// Optional feature macro SUME_SUB_EN enables the '-' key and signed-magnitude subtraction.
module bcd_sume_n #(
  parameter int DIGITS     = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          sample_input,
  output logic [4*DIGITS-1:0] cdu,
  output logic                ovf,
  output logic                neg,
  output logic                valid
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DEB_N = CW'(DEB_CYCLES);
  localparam logic [NW-1:0] DIG_N = NW'(DIGITS);

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_EQ   = 4'hC;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  localparam logic [3:0] KEY_NONE = 4'hF;

`ifdef SUME_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ENTER_A, ENTER_B, CALC, SHOW} state_t;

  // One BCD digit of x+y+cin; returns {carry, digit}.
  function automatic logic [4:0] bcd_add_dig(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    if (s > 5'd9) return {1'b1, 4'(s + 5'd6)};
    return {1'b0, s[3:0]};
  endfunction

  // One BCD digit of x-y-bin; returns {borrow, digit}.
  function automatic logic [4:0] bcd_sub_dig(input logic [3:0] x, input logic [3:0] y,
                                             input logic b);
    logic signed [5:0] d;
    d = $signed({2'b00, x}) - $signed({2'b00, y}) - $signed({5'b00000, b});
    if (d < 0) return {1'b1, 4'(d + 6'sd10)};
    return {1'b0, d[3:0]};
  endfunction

  logic [3:0]    samp_q, code_q;
  logic [CW-1:0] cnt_q, run_d;
  logic          armed_q;
  logic          key_ev, dig_ev, sub_ev, op_ev, eq_ev, clr_ev;

  // run_d counts consecutive cycles the registered code has held, this cycle included
  always_comb begin
    if (samp_q != code_q)    run_d = CW'(1);
    else if (cnt_q == DEB_N) run_d = DEB_N;
    else                     run_d = cnt_q + 1'b1;
    key_ev = armed_q && (samp_q != KEY_NONE) && (run_d == DEB_N);
    dig_ev = key_ev && (samp_q <= 4'd9);
    sub_ev = key_ev && SUB_EN && (samp_q == KEY_SUB);
    op_ev  = sub_ev || (key_ev && (samp_q == KEY_ADD));
    eq_ev  = key_ev && (samp_q == KEY_EQ);
    clr_ev = key_ev && (samp_q == KEY_CLR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q  <= KEY_NONE;
      code_q  <= KEY_NONE;
      cnt_q   <= '0;
      armed_q <= 1'b1;
    end else begin
      samp_q <= sample_input;
      code_q <= samp_q;
      cnt_q  <= run_d;
      if (key_ev)                                   armed_q <= 1'b0;
      else if (samp_q == KEY_NONE && run_d == DEB_N) armed_q <= 1'b1;
    end
  end

  state_t        state_q;
  logic [W-1:0]  a_q, b_q, x_q, y_q, res_q, res_d, a_ins_d, b_ins_d;
  logic [NW-1:0] ndig_q, step_q;
  logic          op_sub_q, sw_q, carry_q, swap_d;
  logic [4:0]    dsum_d;
  logic [W-1:0]  cdu_q;
  logic          ovf_q, neg_q, valid_q;

  // Result digits enter at the top and shift down, so after DIGITS steps the LSD sits at bit 0
  always_comb begin
    swap_d  = op_sub_q && (a_q < b_q);
    dsum_d  = op_sub_q ? bcd_sub_dig(x_q[3:0], y_q[3:0], carry_q)
                       : bcd_add_dig(x_q[3:0], y_q[3:0], carry_q);
    res_d   = (res_q >> 4) | (W'(dsum_d[3:0]) << (W - 4));
    a_ins_d = (a_q << 4) | W'(samp_q);
    b_ins_d = (b_q << 4) | W'(samp_q);
  end

  always_ff @(posedge clk) begin
    if (state_q == ENTER_B && eq_ev) begin
      sw_q    <= swap_d;
      x_q     <= swap_d ? b_q : a_q;
      y_q     <= swap_d ? a_q : b_q;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else if (state_q == CALC) begin
      x_q     <= x_q >> 4;
      y_q     <= y_q >> 4;
      res_q   <= res_d;
      carry_q <= dsum_d[4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_ev) begin
      state_q  <= ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      op_sub_q <= 1'b0;
      ndig_q   <= '0;
      step_q   <= '0;
      cdu_q    <= '0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        ENTER_A: begin
          if (dig_ev) begin
            if (ndig_q != DIG_N) begin
              a_q    <= a_ins_d;
              cdu_q  <= a_ins_d;
              ndig_q <= ndig_q + 1'b1;
            end
          end else if (op_ev) begin
            op_sub_q <= sub_ev;
            b_q      <= '0;
            ndig_q   <= '0;
            cdu_q    <= '0;
            state_q  <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (dig_ev) begin
            if (ndig_q != DIG_N) begin
              b_q    <= b_ins_d;
              cdu_q  <= b_ins_d;
              ndig_q <= ndig_q + 1'b1;
            end
          end else if (op_ev) begin
            op_sub_q <= sub_ev;
          end else if (eq_ev) begin
            step_q  <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          step_q <= step_q + 1'b1;
          if (step_q == DIG_N - 1'b1) begin
            state_q <= SHOW;
            cdu_q   <= res_d;
            ovf_q   <= !op_sub_q && dsum_d[4];
            neg_q   <= sw_q;
            valid_q <= 1'b1;
          end
        end
        SHOW: begin
          if (dig_ev) begin
            state_q <= ENTER_A;
            a_q     <= W'(samp_q);
            b_q     <= '0;
            ndig_q  <= NW'(1);
            cdu_q   <= W'(samp_q);
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            valid_q <= 1'b0;
          end else if (op_ev) begin
            // chaining: the shown magnitude becomes the next A operand
            state_q  <= ENTER_B;
            a_q      <= res_q;
            b_q      <= '0;
            ndig_q   <= '0;
            op_sub_q <= sub_ev;
            cdu_q    <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            valid_q  <= 1'b0;
          end
        end
        default: state_q <= ENTER_A;
      endcase
    end
  end

  assign cdu   = cdu_q;
  assign ovf   = ovf_q;
  assign neg   = neg_q & SUB_EN;
  assign valid = valid_q;

endmodule

// File: tb/tb_bcd_sume_n.sv
// Directed-vector bench for bcd_sume_n: integer-level calculator model compared every cycle,
// plus hand-computed literal expectations. Honours SUME_SUB_EN like the design.
module tb_bcd_sume_n;
  localparam int DIGITS = 3;
  localparam int DEB    = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MODV   = 1000;
  localparam int M_EA = 0, M_EB = 1, M_CALC = 2, M_SHOW = 3;
`ifdef SUME_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic         clk, rst;
  logic [3:0]   sample_input;
  logic [W-1:0] cdu;
  logic         ovf, neg, valid;

  bcd_sume_n #(.DIGITS(DIGITS), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst), .sample_input(sample_input),
    .cdu(cdu), .ovf(ovf), .neg(neg), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Calculator model state (plain integers)
  int   m_a, m_b, m_res, m_nd, m_cc, m_st, m_run;
  int   cyc = 0, m_eq_cyc = 0, rise_cyc = 0;
  logic m_op, m_ovf, m_neg, p_ovf, p_neg, m_armed, m_init = 1'b0, prev_v = 1'b0;
  logic [3:0] m_samp;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_clear();
    m_st = M_EA; m_a = 0; m_b = 0; m_nd = 0; m_op = 1'b0;
    m_ovf = 1'b0; m_neg = 1'b0; m_res = 0;
  endtask

  task automatic model_step(input logic r, input logic [3:0] s);
    logic ev, is_op;
    logic [3:0] k;
    cyc++;
    if (r) begin
      model_clear();
      m_samp = 4'hF; m_run = 1; m_armed = 1'b1; m_init = 1'b1;
      return;
    end
    k  = m_samp;
    ev = m_armed && (k != 4'hF) && (m_run == DEB);
    if (ev) m_armed = 1'b0;
    else if (k == 4'hF && m_run == DEB) m_armed = 1'b1;
    is_op = (k == 4'hA) || (SUB && k == 4'hB);
    if (ev && k == 4'hD) model_clear();
    else if (m_st == M_CALC) begin
      m_cc--;
      if (m_cc == 0) begin m_st = M_SHOW; m_ovf = p_ovf; m_neg = p_neg; end
    end else if (ev) begin
      case (m_st)
        M_EA: begin
          if (k <= 4'd9) begin
            if (m_nd < DIGITS) begin m_a = m_a * 10 + int'(k); m_nd++; end
          end else if (is_op) begin
            m_op = (k == 4'hB); m_b = 0; m_nd = 0; m_st = M_EB;
          end
        end
        M_EB: begin
          if (k <= 4'd9) begin
            if (m_nd < DIGITS) begin m_b = m_b * 10 + int'(k); m_nd++; end
          end else if (is_op) m_op = (k == 4'hB);
          else if (k == 4'hC) begin
            m_st = M_CALC; m_cc = DIGITS; m_eq_cyc = cyc - 1;
            if (!m_op) begin
              m_res = (m_a + m_b) % MODV; p_ovf = (m_a + m_b) >= MODV; p_neg = 1'b0;
            end else begin
              p_ovf = 1'b0; p_neg = (m_a < m_b);
              m_res = (m_a < m_b) ? m_b - m_a : m_a - m_b;
            end
          end
        end
        M_SHOW: begin
          if (k <= 4'd9) begin
            m_st = M_EA; m_a = int'(k); m_b = 0; m_nd = 1; m_ovf = 1'b0; m_neg = 1'b0;
          end else if (is_op) begin
            m_st = M_EB; m_a = m_res; m_b = 0; m_nd = 0; m_op = (k == 4'hB);
            m_ovf = 1'b0; m_neg = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (s == m_samp) begin
      if (m_run < DEB) m_run++;
    end else m_run = 1;
    m_samp = s;
  endtask

  task automatic compare_cycle();
    logic [W-1:0] exp_cdu;
    logic exp_v;
    if (!m_init) return;
    exp_cdu = to_bcd(m_st == M_EA ? m_a : (m_st == M_SHOW ? m_res : m_b));
    exp_v   = (m_st == M_SHOW);
    checks++;
    if (cdu !== exp_cdu || ovf !== m_ovf || neg !== m_neg || valid !== exp_v) begin
      errors++;
      $display("FAIL cycle%0d: cdu=%h ovf=%b neg=%b valid=%b, required cdu=%h ovf=%b neg=%b valid=%b",
               cyc, cdu, ovf, neg, valid, exp_cdu, m_ovf, m_neg, exp_v);
    end
    if (valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
    prev_v = valid;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(rst, sample_input);
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] k, input int n);
    sample_input = k;
    repeat (n) tick();
  endtask

  task automatic press(input logic [3:0] k);
    hold(k, DEB);
    hold(4'hF, DEB + 1);
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) begin
      logic [3:0] k;
      case (s[i])
        "+": k = 4'hA;
        "-": k = 4'hB;
        "=": k = 4'hC;
        "c": k = 4'hD;
        "e": k = 4'hE;
        default: k = 4'(s[i] - "0");
      endcase
      press(k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sample_input = 4'hF;
    repeat (2) tick();
    check("rst_cdu", 32'(cdu), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_neg", 32'(neg), 0);
    rst = 1'b0;
    hold(4'hF, 2);

    keys("1e234");
    check("entry_limit", 32'(cdu), 32'h123);

    keys("+456=");
    check("add579", 32'(cdu), 32'h579);
    check("add579_ovf", 32'(ovf), 0);
    check("add579_valid", 32'(valid), 1);

    keys("+1=");
    check("chain580", 32'(cdu), 32'h580);

    keys("c");
    check("clear_cdu", 32'(cdu), 0);
    check("clear_valid", 32'(valid), 0);

    keys("534+961=");
    check("add495", 32'(cdu), 32'h495);
    check("add495_ovf", 32'(ovf), 1);
    check("add495_neg", 32'(neg), 0);
    check("add495_latency", 32'(rise_cyc - m_eq_cyc), 4);

    hold(4'h7, DEB - 1);
    hold(4'hF, DEB + 1);
    check("short7_cdu", 32'(cdu), 32'h495);
    check("short7_valid", 32'(valid), 1);
    hold(4'h7, 20);
    hold(4'hF, DEB + 1);
    check("long7_cdu", 32'(cdu), 32'h007);
    check("long7_valid", 32'(valid), 0);
    check("long7_ovf", 32'(ovf), 0);

    keys("-");
`ifdef SUME_SUB_EN
    check("minus_enter_b", 32'(cdu), 0);
    keys("c123-456=");
    check("sub_neg_cdu", 32'(cdu), 32'h333);
    check("sub_neg_flag", 32'(neg), 1);
    check("sub_neg_ovf", 32'(ovf), 0);
    keys("c456-123=");
    check("sub_pos_cdu", 32'(cdu), 32'h333);
    check("sub_pos_flag", 32'(neg), 0);
`else
    check("minus_ignored", 32'(cdu), 32'h007);
`endif

    keys("c999+999=");
    check("add998", 32'(cdu), 32'h998);
    check("add998_ovf", 32'(ovf), 1);

    keys("c1+2");
    hold(4'hC, DEB);
    sample_input = 4'hF;
    tick();
    tick();
    check("calc_shows_b", 32'(cdu), 32'h002);
    rst = 1'b1;
    tick();
    check("calc_rst_cdu", 32'(cdu), 0);
    check("calc_rst_valid", 32'(valid), 0);
    rst = 1'b0;
    hold(4'hF, 8);
    check("calc_rst_noresult", 32'(valid), 0);
    keys("5");
    check("calc_rst_enter_a", 32'(cdu), 32'h005);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bcd_sume_n.md
BCD_SUME_N -- requirements
Module: bcd_sume_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 3, giving the number of BCD digits per operand (legal range 1..8).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 4, giving the consecutive stable cycles needed to accept a key press or release (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port sample_input  input  4  keypad code: 0-9 digit, A '+', B '-', C '=', D clear, E ignored, F no key.
REQ-006 The block SHALL have port cdu  output  4*DIGITS  packed BCD display value.
REQ-007 The block SHALL have port ovf  output  1  carry out of the top digit of the last result.
REQ-008 The block SHALL have port neg  output  1  last result is negative; cdu holds the magnitude.
REQ-009 The block SHALL have port valid  output  1  high while cdu shows a computed result.

Function
REQ-010 The block SHALL register sample_input once and generate exactly one key event per press, in the cycle its code has been stable and not F for DEB_CYCLES consecutive cycles.
REQ-011 The block SHALL generate no further event until sample_input has been F for DEB_CYCLES consecutive cycles; any code change restarts the stability count.
REQ-012 The block SHALL use FSM states ENTER_A, ENTER_B, CALC and SHOW.
REQ-013 In ENTER_A and ENTER_B, a digit event SHALL shift the active operand left one digit and insert the new digit; once DIGITS digits are held, further digits SHALL be ignored.
REQ-014 cdu SHALL show A in ENTER_A, B in ENTER_B and CALC, and the result in SHOW.
REQ-015 The '+' or '-' key in ENTER_A SHALL latch the op and move to ENTER_B with B=0; in ENTER_B it SHALL only change the op.
REQ-016 '=' SHALL be ignored in ENTER_A; in ENTER_B it SHALL enter CALC on the next cycle.
REQ-017 CALC SHALL process one digit per cycle, LSD first, with a BCD carry/borrow; SHOW SHALL be entered DIGITS+1 cycles after the '=' event, with valid=1 in that same cycle.
REQ-018 Add SHALL set cdu to the low DIGITS digits of A+B, set ovf to the final carry, and set neg=0.
REQ-019 Subtract SHALL compare A and B as packed values on CALC entry: if A>=B, cdu=A-B and neg=0; otherwise cdu=B-A and neg=1; ovf SHALL be 0.
REQ-020 All key events during CALC SHALL be ignored.
REQ-021 In SHOW, a digit event SHALL go to ENTER_A with A set to that digit and B=0.
REQ-022 In SHOW, '+' or '-' SHALL go to ENTER_B with A set to the result magnitude and B=0; this is chaining.
REQ-023 Leaving SHOW SHALL clear valid, ovf and neg.
REQ-024 The clear key SHALL, in any state including CALC, go to ENTER_A with A=B=0, op=add and all outputs 0.

Reset
REQ-025 With rst high at a clk edge, the state SHALL be ENTER_A, A=B=0, op=add, cdu=0, ovf=0, neg=0, valid=0, and the debounce counters and last accepted code (F) SHALL be cleared.
REQ-026 Reset SHALL override any event in the same cycle, and reset during CALC SHALL abort the calculation with no result shown.

Configuration
REQ-027 With macro SUME_SUB_EN defined, the '-' key and subtraction SHALL be supported as specified.
REQ-028 With SUME_SUB_EN undefined, the '-' key SHALL be treated like code E (ignored), the op SHALL always be add, and neg SHALL be tied to 0.

Verification
REQ-029 With DIGITS=3, entering 5,3,4,'+',9,6,1,'=' SHALL give cdu=12'h495, ovf=1, neg=0, and valid rising 4 cycles after the '=' event.
REQ-030 Entering 1,2,3,'+',4,5,6,'=' SHALL give cdu=12'h579, ovf=0; a following '+',1,'=' SHALL give cdu=12'h580.
REQ-031 With SUME_SUB_EN defined, entering 1,2,3,'-',4,5,6,'=' SHALL give cdu=12'h333, neg=1; entering 4,5,6,'-',1,2,3,'=' SHALL give cdu=12'h333, neg=0.
REQ-032 Digit 7 held for DEB_CYCLES-1 cycles then F SHALL change nothing; digit 7 held for 20 cycles SHALL insert one digit only.
REQ-033 Entering 1,2,3,4 in ENTER_A SHALL give cdu=12'h123.
REQ-034 rst asserted in the second CALC cycle SHALL give cdu=0, valid=0 and state ENTER_A on the next cycle.
